// File: rtl/data_sram_resp_pkg.sv
// Shared constants and FSM state type for the data-SRAM responder.
package data_sram_resp_pkg;

  localparam int unsigned RegBus      = 32;
  localparam logic [RegBus-1:0] ZeroWord = '0;
  localparam logic        RstEnable   = 1'b1;
  localparam logic        ChipEnable  = 1'b1;
  localparam logic        WriteEnable = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/data_sram_resp_sram_bank.sv
// Word-organised storage with per-byte write enables and a registered read port.
module sram_bank
  import data_sram_resp_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              re_i,
  input  logic [3:0]        be_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [RegBus-1:0] wdata_i,
  output logic [RegBus-1:0] rdata_o
);

  logic [RegBus-1:0] mem_q [2**ADDR_W];
  logic [RegBus-1:0] rdata_q;

  // Array contents survive reset; only the read register is cleared.
  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (be_i[i]) begin
        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i == RstEnable) begin
      rdata_q <= ZeroWord;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_sram_resp.sv
// MEM-stage data SRAM responder: wait-state handshake around a byte-writable bank.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       mem_data_i,
  output logic [31:0]       mem_data_o,
  output logic              stall_o
);

  localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

  state_e            state_q;
  logic [3:0]        wait_cnt_q;
  logic [ADDR_W-1:0] idx_q;
  logic              we_q;
  logic [3:0]        sel_q;
  logic [31:0]       wdata_q;

  logic              ce_req;
  logic              fire;
  logic [ADDR_W-1:0] in_idx;
  logic [ADDR_W-1:0] idx_m;
  logic              we_m;
  logic [3:0]        sel_m;
  logic [31:0]       wdata_m;
  logic [3:0]        bank_be;
  logic              bank_re;
  logic              unused_addr_bits;

  assign ce_req           = (mem_ce_i == ChipEnable);
  assign in_idx           = mem_addr_i[ADDR_W+1:2];
  assign unused_addr_bits = ^{mem_addr_i[31:ADDR_W+2], mem_addr_i[1:0]};

  // In IDLE the access may complete on this very edge (zero wait), so the bank
  // is driven from the live inputs; otherwise from the captured request.
  always_comb begin
    idx_m   = idx_q;
    we_m    = we_q;
    sel_m   = sel_q;
    wdata_m = wdata_q;
    fire    = 1'b0;
    if (state_q == IDLE) begin
      idx_m   = in_idx;
      we_m    = (mem_we_i == WriteEnable);
      sel_m   = mem_sel_i;
      wdata_m = mem_data_i;
    end
    unique case (state_q)
      IDLE:    fire = ce_req && (WAIT_CYCLES == 0);
      BUSY:    fire = ce_req && (wait_cnt_q == 4'd1);
      default: fire = 1'b0;
    endcase
  end

  assign bank_be = (fire && we_m) ? sel_m : '0;
  assign bank_re = fire && !we_m;
  assign stall_o = (rst != RstEnable) &&
                   (((state_q == IDLE) && ce_req) || (state_q == BUSY));

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      idx_q      <= '0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      wdata_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ce_req) begin
            idx_q   <= in_idx;
            we_q    <= (mem_we_i == WriteEnable);
            sel_q   <= mem_sel_i;
            wdata_q <= mem_data_i;
            if (WAIT_CYCLES == 0) begin
              state_q <= DONE;
            end else begin
              state_q    <= BUSY;
              wait_cnt_q <= WaitInit;
            end
          end
        end
        BUSY: begin
          if (!ce_req) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
          end else if (wait_cnt_q == 4'd1) begin
            state_q    <= DONE;
            wait_cnt_q <= '0;
          end else begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  sram_bank #(
    .ADDR_W(ADDR_W)
  ) u_bank (
    .clk_i  (clk),
    .rst_i  (rst),
    .re_i   (bank_re),
    .be_i   (bank_be),
    .addr_i (idx_m),
    .wdata_i(wdata_m),
    .rdata_o(mem_data_o)
  );

endmodule

// File: tb/tb_data_sram_resp.sv
// Randomised bench for data_sram_resp at three wait settings against a word-array model.
module tb_data_sram_resp;

  localparam int AW = 6;
  localparam int NW = 64;

  logic        clk = 1'b0;
  logic        rst   [3];
  logic        ce    [3];
  logic        we    [3];
  logic [3:0]  sel   [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [31:0] dout  [3];
  logic        stall [3];

  logic [31:0] mdl  [3][NW];
  logic [31:0] last [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  data_sram_resp #(.ADDR_W(AW), .WAIT_CYCLES(1)) u_dut0 (
    .clk(clk), .rst(rst[0]), .mem_ce_i(ce[0]), .mem_we_i(we[0]), .mem_sel_i(sel[0]),
    .mem_addr_i(addr[0]), .mem_data_i(wdata[0]), .mem_data_o(dout[0]), .stall_o(stall[0]));
  data_sram_resp #(.ADDR_W(AW), .WAIT_CYCLES(0)) u_dut1 (
    .clk(clk), .rst(rst[1]), .mem_ce_i(ce[1]), .mem_we_i(we[1]), .mem_sel_i(sel[1]),
    .mem_addr_i(addr[1]), .mem_data_i(wdata[1]), .mem_data_o(dout[1]), .stall_o(stall[1]));
  data_sram_resp #(.ADDR_W(AW), .WAIT_CYCLES(3)) u_dut2 (
    .clk(clk), .rst(rst[2]), .mem_ce_i(ce[2]), .mem_we_i(we[2]), .mem_sel_i(sel[2]),
    .mem_addr_i(addr[2]), .mem_data_i(wdata[2]), .mem_data_o(dout[2]), .stall_o(stall[2]));

  function automatic int wait_of(input int d);
    case (d)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % NW);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full handshake; stall is checked on every cycle, data in the completion cycle.
  task automatic access(input int d, input logic w, input logic [3:0] s,
                        input logic [31:0] a, input logic [31:0] dat);
    int i;
    @(negedge clk);
    ce[d] = 1'b1; we[d] = w; sel[d] = s; addr[d] = a; wdata[d] = dat;
    #1 chk("stall_first", 32'(stall[d]), 32'd1);
    for (int k = 0; k < wait_of(d); k++) begin
      @(negedge clk);
      #1 chk("stall_wait", 32'(stall[d]), 32'd1);
    end
    @(negedge clk);
    i = idx_of(a);
    if (w) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) mdl[d][i][8*b +: 8] = dat[8*b +: 8];
    end else begin
      last[d] = mdl[d][i];
    end
    #1;
    chk("stall_done", 32'(stall[d]), 32'd0);
    chk(w ? "data_after_store" : "load_data", dout[d], last[d]);
    ce[d] = 1'b0;
    @(negedge clk);
    #1;
    chk("stall_idle", 32'(stall[d]), 32'd0);
    chk("data_hold", dout[d], last[d]);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; ce[d] = 1'b0; we[d] = 1'b0; sel[d] = '0;
      addr[d] = '0; wdata[d] = '0; last[d] = '0;
    end
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("reset_stall", 32'(stall[d]), 32'd0);
      chk("reset_data", dout[d], 32'd0);
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;

    for (int d = 0; d < 3; d++)
      for (int i = 0; i < NW; i++)
        access(d, 1'b1, 4'hF, 32'(i * 4), $urandom);

    access(0, 1'b1, 4'hF, 32'h10, 32'hA1B2C3D4);
    access(0, 1'b0, 4'h0, 32'h10, 32'h0);
    chk("sw_lw_10", dout[0], 32'hA1B2C3D4);
    access(0, 1'b1, 4'hF, 32'h10, 32'h11223344);
    access(0, 1'b1, 4'h8, 32'h13, 32'h5A5A5A5A);
    access(0, 1'b0, 4'h0, 32'h10, 32'h0);
    chk("sb_merge", dout[0], 32'h5A223344);
    access(0, 1'b1, 4'hF, 32'h8, 32'hDEADBEEF);
    access(0, 1'b1, 4'h0, 32'h8, 32'h0);
    access(0, 1'b0, 4'h0, 32'h8, 32'h0);
    chk("sel0_nowrite", dout[0], 32'hDEADBEEF);
    access(0, 1'b1, 4'hF, 32'hFFFF_FF04 + 32'(NW * 4), 32'hCAFEF00D);
    access(0, 1'b0, 4'h0, 32'h6, 32'h0);
    chk("alias", dout[0], 32'hCAFEF00D);

    // Reset in the middle of a store: the store is dropped, data output clears.
    @(negedge clk);
    ce[0] = 1'b1; we[0] = 1'b1; sel[0] = 4'hF; addr[0] = 32'hC; wdata[0] = 32'h0BADC0DE;
    #1 chk("rst_pre_stall", 32'(stall[0]), 32'd1);
    @(negedge clk);
    rst[0] = 1'b1; ce[0] = 1'b0;
    #1;
    chk("rst_mid_stall", 32'(stall[0]), 32'd0);
    chk("rst_mid_data", dout[0], 32'd0);
    last[0] = '0;
    @(negedge clk);
    rst[0] = 1'b0;
    access(0, 1'b0, 4'h0, 32'hC, 32'h0);

    for (int k = 0; k < 8; k++)
      access(1, k[0], 4'hF, (k[1] ? 32'h4 : 32'h0), $urandom);

    // Chip enable withdrawn while busy: abort, no write, stall falls next cycle.
    @(negedge clk);
    ce[2] = 1'b1; we[2] = 1'b1; sel[2] = 4'hF; addr[2] = 32'h14; wdata[2] = ~mdl[2][5];
    #1 chk("abort_first", 32'(stall[2]), 32'd1);
    @(negedge clk);
    ce[2] = 1'b0;
    #1 chk("abort_busy", 32'(stall[2]), 32'd1);
    @(negedge clk);
    #1;
    chk("abort_stall", 32'(stall[2]), 32'd0);
    chk("abort_data", dout[2], last[2]);
    repeat (4) @(negedge clk);
    #1 chk("abort_idle", 32'(stall[2]), 32'd0);
    access(2, 1'b0, 4'h0, 32'h14, 32'h0);

    for (int d = 0; d < 3; d++)
      for (int n = 0; n < 60; n++)
        access(d, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, $urandom);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
